// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers payload bytes, then sends header,
// payload and parity on data_out/pkt_valid while honouring router busy.
module router_pkt_tx #(
  parameter int unsigned DEPTH = 63,
  parameter int unsigned IFG   = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_rdy,
  output logic [5:0] buf_count,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic       inject_err,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       start_err
);

  localparam int unsigned CW = 6;
  localparam int unsigned GW = (IFG < 2) ? 1 : $clog2(IFG + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [CW-1:0]   wr_ptr, rd_ptr, rem;
  logic [7:0]      par;
  logic            err;
  logic [GW-1:0]   gap_cnt;

  logic            in_xfer, acc, wr_ok, pop, start_ok;
  logic [CW-1:0]   count_nxt, rem_nxt;
  logic [7:0]      data_nxt, par_nxt, head_byte;
  logic            pv_nxt, err_nxt, done_nxt, serr_nxt, tx_nxt, rdy_nxt;
  logic [GW-1:0]   gap_nxt;

  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    return (p == CW'(DEPTH - 1)) ? '0 : p + CW'(1);
  endfunction

  // Handshake qualifiers shared by the FSM and the datapath
  always_comb begin
    in_xfer   = (state == S_HEADER) || (state == S_PAYLOAD) || (state == S_PARITY);
    acc       = in_xfer && !busy;
    wr_ok     = wr_en && wr_rdy;
    pop       = acc && (state != S_PARITY) && (rem != '0);
    start_ok  = start && (buf_count != '0) && (dest_addr != 2'b11);
    head_byte = mem[rd_ptr];
    count_nxt = buf_count + CW'(wr_ok) - CW'(pop);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_ok) state_nxt = S_HEADER;
      S_HEADER,
      S_PAYLOAD: if (acc) state_nxt = (rem != '0) ? S_PAYLOAD : S_PARITY;
      S_PARITY:  if (acc) state_nxt = S_GAP;
      S_GAP:     if (gap_cnt == '0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values for every registered output and datapath register
  always_comb begin
    data_nxt = data_out;
    pv_nxt   = pkt_valid;
    par_nxt  = par;
    err_nxt  = err;
    rem_nxt  = rem;
    gap_nxt  = gap_cnt;
    done_nxt = 1'b0;
    serr_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          rem_nxt  = buf_count;
          data_nxt = {buf_count, dest_addr};
          pv_nxt   = 1'b1;
          par_nxt  = {buf_count, dest_addr};
          err_nxt  = inject_err;
        end else if (start) begin
          serr_nxt = 1'b1;
        end
      end
      S_HEADER, S_PAYLOAD: begin
        if (acc) begin
          if (rem != '0) begin
            data_nxt = head_byte;
            par_nxt  = par ^ head_byte;
            rem_nxt  = rem - CW'(1);
          end else begin
            data_nxt = err ? ~par : par;
            pv_nxt   = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (acc) begin
          data_nxt = 8'h00;
          gap_nxt  = GW'(IFG);
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) gap_nxt = gap_cnt - GW'(1);
        else               done_nxt = 1'b1;
      end
      default: ;
    endcase
    tx_nxt  = (state_nxt != S_IDLE);
    rdy_nxt = (state_nxt == S_IDLE) && (count_nxt < CW'(DEPTH));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out  <= '0;
      pkt_valid <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      wr_rdy    <= 1'b0;
      buf_count <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rem       <= '0;
      par       <= '0;
      err       <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      data_out  <= data_nxt;
      pkt_valid <= pv_nxt;
      tx_active <= tx_nxt;
      done      <= done_nxt;
      start_err <= serr_nxt;
      wr_rdy    <= rdy_nxt;
      buf_count <= count_nxt;
      rem       <= rem_nxt;
      par       <= par_nxt;
      err       <= err_nxt;
      gap_cnt   <= gap_nxt;
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Payload storage needs no reset; pointers define validity
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule
